// File: rtl/wshb_mire_if.sv
// Wishbone bus bundle between the test-pattern master and the intercon.
// The master drives address, data and the classic-cycle controls. The slave
// side only returns the acknowledge.
interface wshb_mire_if;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_ms;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic        wb_ack;

    modport master (
        output wb_adr, wb_dat_ms, wb_sel, wb_we, wb_cyc, wb_stb, wb_cti, wb_bte,
        input  wb_ack
    );

    modport slave (
        input  wb_adr, wb_dat_ms, wb_sel, wb_we, wb_cyc, wb_stb, wb_cti, wb_bte,
        output wb_ack
    );
endinterface

// File: rtl/wshb_mire.sv
// wshb_mire: Wishbone master that writes an 8-bar colour test pattern into
// the framebuffer. Pixels are written in raster order, one classic write per
// pixel. cyc is released for GAP cycles after every BURST writes so that the
// arbiter can grant the display reader.
//
// Optional feature macro: MIRE_SCROLL_EN
//   undefined : one frame per start pulse, static bars.
//   defined   : frames loop forever after the first start. The bars shift one
//               pixel per completed frame.
module wshb_mire #(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    parameter int BURST = 64,
    parameter int GAP   = 4
) (
    input  logic        wshb_clk,
    input  logic        wshb_rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] frame_cnt,
    wshb_mire_if.master wb
);
    localparam int BAR_W = HDISP / 8;
    localparam int XW    = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW    = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int BCW   = $clog2(BURST + 1);
    localparam int GCW   = $clog2(GAP + 1);
    localparam int BWW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [XW-1:0]  X_LAST   = XW'(HDISP - 1);
    localparam logic [YW-1:0]  Y_LAST   = YW'(VDISP - 1);
    localparam logic [BCW-1:0] B_LAST   = BCW'(BURST - 1);
    localparam logic [GCW-1:0] G_LAST   = GCW'(GAP - 1);
    localparam logic [BWW-1:0] BAR_LAST = BWW'(BAR_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_REST, S_DONE} state_t;

    state_t         state, state_nxt;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [31:0]    adr;
    logic [BCW-1:0] burst_cnt;
    logic [GCW-1:0] gap_cnt;
    logic [2:0]     bar_idx;
    logic [BWW-1:0] bar_cnt;   // pixels left in the current bar after this one
    logic [2:0]     line_idx;  // bar index of the first pixel of a line
    logic [BWW-1:0] line_cnt;  // bar down-counter preload for the first pixel
    logic           frame_end;
    logic           burst_end;

    // Bar colour packed as {B, G, R}.
    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_rgb = 24'hFFFFFF;  // white
            3'd1:    bar_rgb = 24'h00FFFF;  // yellow
            3'd2:    bar_rgb = 24'hFFFF00;  // cyan
            3'd3:    bar_rgb = 24'h00FF00;  // green
            3'd4:    bar_rgb = 24'hFF00FF;  // magenta
            3'd5:    bar_rgb = 24'h0000FF;  // red
            3'd6:    bar_rgb = 24'hFF0000;  // blue
            default: bar_rgb = 24'h000000;  // black
        endcase
    endfunction

    assign frame_end = (x == X_LAST) && (y == Y_LAST);
    assign burst_end = (burst_cnt == B_LAST);

`ifdef MIRE_SCROLL_EN
    // The scroll offset is held as the (bar index, down-counter) pair of
    // xs at x = 0. This lets each line start preload without a divider.
    logic [2:0]     off_idx, off_idx_nxt;
    logic [BWW-1:0] off_cnt, off_cnt_nxt;

    // Advance the offset by one pixel and wrap at HDISP (bar 7 -> bar 0).
    always_comb begin
        off_idx_nxt = off_idx;
        off_cnt_nxt = off_cnt - BWW'(1);
        if (off_cnt == '0) begin
            off_cnt_nxt = BAR_LAST;
            off_idx_nxt = off_idx + 3'd1;
        end
    end

    // Offset register: bumped once per completed frame.
    always_ff @(posedge wshb_clk or negedge wshb_rst_n) begin
        if (!wshb_rst_n) begin
            off_idx <= 3'd0;
            off_cnt <= BAR_LAST;
        end else if (state == S_DONE) begin
            off_idx <= off_idx_nxt;
            off_cnt <= off_cnt_nxt;
        end
    end

    assign line_idx = off_idx;
    assign line_cnt = off_cnt;
`else
    assign line_idx = 3'd0;
    assign line_cnt = BAR_LAST;
`endif

    // State register.
    always_ff @(posedge wshb_clk or negedge wshb_rst_n) begin
        if (!wshb_rst_n) state <= S_IDLE;
        else             state <= state_nxt;
    end

    // Next-state logic. The last pixel of a frame wins over a burst end.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_WRITE;
            S_WRITE: if (wb.wb_ack) begin
                if (frame_end)      state_nxt = S_DONE;
                else if (burst_end) state_nxt = S_REST;
            end
            S_REST:  if (gap_cnt == G_LAST) state_nxt = S_WRITE;
`ifdef MIRE_SCROLL_EN
            S_DONE:  state_nxt = S_WRITE;
`else
            S_DONE:  state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode. cyc/stb come straight from the state, so reset drops them at once.
    always_comb begin
        busy          = (state != S_IDLE);
        done          = (state == S_DONE);
        wb.wb_cyc     = (state == S_WRITE);
        wb.wb_stb     = (state == S_WRITE);
        wb.wb_adr     = adr;
        wb.wb_dat_ms  = {8'h00, bar_rgb(bar_idx)};
    end

    assign wb.wb_sel = 4'b1111;
    assign wb.wb_we  = 1'b1;
    assign wb.wb_cti = 3'b000;
    assign wb.wb_bte = 2'b00;

    // Pixel walk, bus tenure and frame counters. Nothing moves without an ack,
    // so adr/dat hold steady through a stall.
    always_ff @(posedge wshb_clk or negedge wshb_rst_n) begin
        if (!wshb_rst_n) begin
            x         <= '0;
            y         <= '0;
            adr       <= 32'd0;
            burst_cnt <= '0;
            gap_cnt   <= '0;
            bar_idx   <= 3'd0;
            bar_cnt   <= BAR_LAST;
            frame_cnt <= 16'd0;
        end else begin
            gap_cnt <= '0;
            case (state)
                S_WRITE: if (wb.wb_ack) begin
                    if (x == X_LAST) begin
                        x       <= '0;
                        bar_idx <= line_idx;
                        bar_cnt <= line_cnt;
                        if (y == Y_LAST) begin
                            y   <= '0;
                            adr <= 32'd0;
                        end else begin
                            y   <= y + YW'(1);
                            adr <= adr + 32'd4;
                        end
                    end else begin
                        x   <= x + XW'(1);
                        adr <= adr + 32'd4;
                        if (bar_cnt == '0) begin
                            bar_cnt <= BAR_LAST;
                            bar_idx <= bar_idx + 3'd1;
                        end else begin
                            bar_cnt <= bar_cnt - BWW'(1);
                        end
                    end
                    if (frame_end || burst_end) burst_cnt <= '0;
                    else                        burst_cnt <= burst_cnt + BCW'(1);
                end
                S_REST: gap_cnt <= gap_cnt + GCW'(1);
                S_DONE: begin
                    frame_cnt <= frame_cnt + 16'd1;
`ifdef MIRE_SCROLL_EN
                    bar_idx   <= off_idx_nxt;
                    bar_cnt   <= off_cnt_nxt;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wshb_mire.sv
// Testbench for wshb_mire with a small frame (32x4, bursts of 8, gap of 4).
// A responder acks one cycle after each strobe. Expected {adr, dat} pairs are
// queued when a frame is started and popped as each write is acknowledged.
module tb_wshb_mire;
    localparam int HDISP = 32;
    localparam int VDISP = 4;
    localparam int BURST = 8;
    localparam int GAP   = 4;
    localparam int NPIX  = HDISP * VDISP;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] frame_cnt;

    wshb_mire_if bus();

    wshb_mire #(.HDISP(HDISP), .VDISP(VDISP), .BURST(BURST), .GAP(GAP)) dut (
        .wshb_clk   (clk),
        .wshb_rst_n (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .frame_cnt  (frame_cnt),
        .wb         (bus.slave)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          wr_cnt   = 0;
    int          stall_at = -1;
    int          pend     = 0;
    logic [63:0] hold;
    logic [63:0] exp_wr;
    logic [63:0] sb[$];

    // Reference colour: bar = xs / (HDISP/8), colour table as {8'h00, B, G, R}.
    function automatic logic [31:0] exp_dat(input int x, input int off);
        int xs;
        xs = (x + off) % HDISP;
        case (xs / (HDISP / 8))
            0: exp_dat = 32'h00FFFFFF;
            1: exp_dat = 32'h0000FFFF;
            2: exp_dat = 32'h00FFFF00;
            3: exp_dat = 32'h0000FF00;
            4: exp_dat = 32'h00FF00FF;
            5: exp_dat = 32'h000000FF;
            6: exp_dat = 32'h00FF0000;
            default: exp_dat = 32'h00000000;
        endcase
    endfunction

    // Slave responder and scoreboard. Ack is raised one cycle after stb,
    // or 11 cycles after stb for the write index held in stall_at.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.wb_ack = 1'b0;
            pend = 0;
            sb.delete();
        end else if (!bus.wb_stb || bus.wb_ack) begin
            bus.wb_ack = 1'b0;
            pend = 0;
        end else begin
            pend++;
            if (pend == 1) begin
                hold = {bus.wb_adr, bus.wb_dat_ms};
            end else begin
                n_checks++;
                if ({bus.wb_adr, bus.wb_dat_ms} !== hold)
                    $display("FAIL stall_hold: got %h want %h", {bus.wb_adr, bus.wb_dat_ms}, hold);
                else n_pass++;
            end
            if (pend > ((wr_cnt == stall_at) ? 11 : 1)) begin
                bus.wb_ack = 1'b1;
                wr_cnt++;
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_write: got adr %h dat %h want no write", bus.wb_adr, bus.wb_dat_ms);
                end else begin
                    exp_wr = sb.pop_front();
                    if ({bus.wb_adr, bus.wb_dat_ms} !== exp_wr)
                        $display("FAIL write_%0d: got adr %h dat %h want adr %h dat %h",
                                 wr_cnt - 1, bus.wb_adr, bus.wb_dat_ms, exp_wr[63:32], exp_wr[31:0]);
                    else n_pass++;
                end
            end
        end
    end

    task automatic push_frame(input int off);
        for (int y = 0; y < VDISP; y++)
            for (int x = 0; x < HDISP; x++)
                sb.push_back({32'(4 * (y * HDISP + x)), exp_dat(x, off)});
    endtask

    task automatic wait_frame(input int budget, input bit poke, input int base,
                              output int n_done, output int gaps, output int bad_gaps,
                              output bit timed_out);
        int low;
        low = 0; n_done = 0; gaps = 0; bad_gaps = 0; timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            start = poke && (i == 30 || i == 200);
            if (bus.wb_cyc) begin
                if (low > 0) begin
                    gaps++;
                    if (low != GAP || ((wr_cnt - base) % BURST) != 0) bad_gaps++;
                end
                low = 0;
            end else if (busy && !done) begin
                low++;
            end
            if (done) n_done++;
            if (!busy && n_done > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.wb_cyc !== 1'b0) $display("FAIL reset_cyc: got %b want 0", bus.wb_cyc); else n_pass++;
        n_checks++; if (bus.wb_stb !== 1'b0) $display("FAIL reset_stb: got %b want 0", bus.wb_stb); else n_pass++;
        n_checks++; if (bus.wb_adr !== 32'd0) $display("FAIL reset_adr: got %h want 0", bus.wb_adr); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); else n_pass++;
        n_checks++;
        if ({bus.wb_sel, bus.wb_we, bus.wb_cti, bus.wb_bte} !== {4'b1111, 1'b1, 3'b000, 2'b00})
            $display("FAIL bus_constants: got %b want 1111_1_000_00",
                     {bus.wb_sel, bus.wb_we, bus.wb_cti, bus.wb_bte});
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_after_reset: got busy %b want 0", busy); else n_pass++;
    endtask

`ifndef MIRE_SCROLL_EN
    task automatic test_frame();
        int base, nd, gp, bg;
        bit to;
        base = wr_cnt;
        push_frame(0);
        start = 1'b1;
        wait_frame(3000, 1'b0, base, nd, gp, bg, to);
        #1;
        n_checks++; if (to !== 1'b0) $display("FAIL frame_timeout: got timeout want completion"); else n_pass++;
        n_checks++; if (nd !== 1) $display("FAIL frame_done_pulses: got %0d want 1", nd); else n_pass++;
        n_checks++; if (wr_cnt - base !== NPIX) $display("FAIL frame_writes: got %0d want %0d", wr_cnt - base, NPIX); else n_pass++;
        n_checks++; if (frame_cnt !== 16'd1) $display("FAIL frame_cnt1: got %0d want 1", frame_cnt); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL frame_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (sb.size() !== 0) $display("FAIL frame_leftover: got %0d want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_burst_gaps();
        int base, nd, gp, bg;
        bit to;
        base = wr_cnt;
        push_frame(0);
        start = 1'b1;
        wait_frame(3000, 1'b0, base, nd, gp, bg, to);
        #1;
        n_checks++; if (to !== 1'b0) $display("FAIL gaps_timeout: got timeout want completion"); else n_pass++;
        n_checks++; if (gp !== NPIX / BURST - 1) $display("FAIL gap_count: got %0d want %0d", gp, NPIX / BURST - 1); else n_pass++;
        n_checks++; if (bg !== 0) $display("FAIL gap_shape: got %0d bad gaps want 0", bg); else n_pass++;
        n_checks++; if (frame_cnt !== 16'd2) $display("FAIL frame_cnt2: got %0d want 2", frame_cnt); else n_pass++;
    endtask

    task automatic test_stall();
        int base, nd, gp, bg;
        bit to;
        base = wr_cnt;
        stall_at = base + 5;
        push_frame(0);
        start = 1'b1;
        wait_frame(3000, 1'b0, base, nd, gp, bg, to);
        #1;
        stall_at = -1;
        n_checks++; if (to !== 1'b0) $display("FAIL stall_timeout: got timeout want completion"); else n_pass++;
        n_checks++; if (wr_cnt - base !== NPIX) $display("FAIL stall_writes: got %0d want %0d", wr_cnt - base, NPIX); else n_pass++;
        n_checks++; if (frame_cnt !== 16'd3) $display("FAIL frame_cnt3: got %0d want 3", frame_cnt); else n_pass++;
        n_checks++; if (sb.size() !== 0) $display("FAIL stall_leftover: got %0d want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_start_while_busy();
        int base, nd, gp, bg;
        bit to;
        base = wr_cnt;
        push_frame(0);
        start = 1'b1;
        wait_frame(3000, 1'b1, base, nd, gp, bg, to);
        repeat (20) @(negedge clk);
        n_checks++; if (to !== 1'b0) $display("FAIL busy_start_timeout: got timeout want completion"); else n_pass++;
        n_checks++; if (nd !== 1) $display("FAIL busy_start_done: got %0d want 1", nd); else n_pass++;
        n_checks++; if (wr_cnt - base !== NPIX) $display("FAIL busy_start_writes: got %0d want %0d", wr_cnt - base, NPIX); else n_pass++;
        n_checks++; if (frame_cnt !== 16'd4) $display("FAIL frame_cnt4: got %0d want 4", frame_cnt); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL busy_start_idle: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int base, nd, gp, bg;
        bit to, hit;
        base = wr_cnt;
        push_frame(0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            if (wr_cnt - base >= 50) begin
                hit = 1'b1;
                break;
            end
        end
        #2;
        n_checks++; if (hit !== 1'b1) $display("FAIL midreset_reach: got %0d writes want 50", wr_cnt - base); else n_pass++;
        n_checks++; if (bus.wb_cyc !== 1'b1) $display("FAIL midreset_cyc_before: got %b want 1", bus.wb_cyc); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.wb_cyc !== 1'b0) $display("FAIL midreset_cyc: got %b want 0", bus.wb_cyc); else n_pass++;
        n_checks++; if (bus.wb_stb !== 1'b0) $display("FAIL midreset_stb: got %b want 0", bus.wb_stb); else n_pass++;
        n_checks++; if (bus.wb_adr !== 32'd0) $display("FAIL midreset_adr: got %h want 0", bus.wb_adr); else n_pass++;
        n_checks++; if (frame_cnt !== 16'd0) $display("FAIL midreset_frame_cnt: got %0d want 0", frame_cnt); else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = wr_cnt;
        push_frame(0);
        start = 1'b1;
        wait_frame(3000, 1'b0, base, nd, gp, bg, to);
        #1;
        n_checks++; if (wr_cnt - base !== NPIX) $display("FAIL restart_writes: got %0d want %0d", wr_cnt - base, NPIX); else n_pass++;
        n_checks++; if (frame_cnt !== 16'd1) $display("FAIL restart_frame_cnt: got %0d want 1", frame_cnt); else n_pass++;
    endtask
`else
    task automatic test_scroll();
        int base;
        bit hit;
        base = wr_cnt;
        push_frame(0);
        push_frame(1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (frame_cnt == 16'd2) begin
                hit = 1'b1;
                break;
            end
        end
        #1;
        n_checks++; if (hit !== 1'b1) $display("FAIL scroll_timeout: got frame_cnt %0d want 2", frame_cnt); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL scroll_busy: got %b want 1", busy); else n_pass++;
        n_checks++; if (wr_cnt - base !== 2 * NPIX) $display("FAIL scroll_writes: got %0d want %0d", wr_cnt - base, 2 * NPIX); else n_pass++;
        n_checks++; if (sb.size() !== 0) $display("FAIL scroll_leftover: got %0d want 0", sb.size()); else n_pass++;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
`ifndef MIRE_SCROLL_EN
        test_frame();
        test_burst_gaps();
        test_stall();
        test_start_while_busy();
        test_reset_mid_frame();
`else
        test_scroll();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
